hamming_dec_engine: RTL and testbench

- Hardware SECDED decoder, the receive side of the program-1 Hamming encoding format.
- Walks NUM_WORDS 16-bit encoded words in data memory and corrects single-bit errors.
- Flags double-bit errors.
- Writes each recovered 11-bit message plus a 2-bit status back to memory, then raises done.
- Sits beside TopLevel's data memory as an accelerator using the same start/done handshake.

---
 rtl/hamming_dec_engine.sv | 169 ++++++++++++++++
 tb/tb_hamming_dec_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_dec_engine.sv
// SECDED decoder for 16-bit extended-Hamming words held in byte memory.
// Reads NUM_WORDS words, corrects single errors, flags double errors, writes 11-bit data + 2-bit status.
module hamming_dec_engine #(
   parameter int SRC_BASE  = 30,
   parameter int DST_BASE  = 0,
   parameter int NUM_WORDS = 15,
   parameter int CW        = $clog2(NUM_WORDS + 1)
) (
   input  logic          CLK,
   input  logic          rst_n,
   input  logic          start,
   output logic          done,
   output logic [7:0]    mem_addr,
   input  logic [7:0]    mem_rd_data,
   output logic          mem_wr_en,
   output logic [7:0]    mem_wr_data,
   output logic [CW-1:0] n_corrected,
   output logic [CW-1:0] n_uncorrectable
);

   localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, FIN} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    lo_q, lo_d;
   logic [7:0]    hi_q, hi_d;
   logic [7:0]    out_hi_q, out_hi_d;
   logic          done_q, done_d;
   logic [7:0]    addr_q, addr_d;
   logic          wr_en_q, wr_en_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic [CW-1:0] ncor_q, ncor_d;
   logic [CW-1:0] nunc_q, nunc_d;

   function automatic logic [7:0] word_addr(input int base, input logic [IW-1:0] i, input logic hi);
      logic [7:0] off;
      off = 8'({i, 1'b0});
      return 8'(base) + off + {7'd0, hi};
   endfunction

   // Decode of the currently latched raw word.
   logic [15:0] w, wc;
   logic [3:0]  syn;
   logic        par;
   logic [1:0]  flag;
   logic [10:0] data;

   always_comb begin
      w   = {hi_q, lo_q};
      syn = '0;
      for (int k = 1; k < 16; k++) begin
         if (w[k]) syn = syn ^ 4'(k);
      end
      par  = ^w;
      wc   = w;
      flag = 2'b00;
      if (par) begin
         wc[syn] = ~w[syn];
         flag    = 2'b01;
      end else if (syn != 4'd0) begin
         flag = 2'b10;
      end
      data = {wc[15:9], wc[7:5], wc[3]};
   end

   // Bus outputs are registered, so each transition precomputes the next state's address/strobe.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      lo_d      = lo_q;
      hi_d      = hi_q;
      out_hi_d  = out_hi_q;
      done_d    = done_q;
      addr_d    = addr_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      ncor_d    = ncor_q;
      nunc_d    = nunc_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               ncor_d  = '0;
               nunc_d  = '0;
               idx_d   = '0;
               done_d  = 1'b0;
               addr_d  = word_addr(SRC_BASE, '0, 1'b0);
               state_d = RD_LO;
            end
         end
         RD_LO: begin
            lo_d    = mem_rd_data;
            addr_d  = word_addr(SRC_BASE, idx_q, 1'b1);
            state_d = RD_HI;
         end
         RD_HI: begin
            hi_d    = mem_rd_data;
            state_d = DECODE;
         end
         DECODE: begin
            out_hi_d = {flag, 3'b000, data[10:8]};
            if (flag == 2'b01 && ncor_q != '1) ncor_d = ncor_q + CW'(1);
            if (flag == 2'b10 && nunc_q != '1) nunc_d = nunc_q + CW'(1);
            addr_d    = word_addr(DST_BASE, idx_q, 1'b0);
            wr_en_d   = 1'b1;
            wr_data_d = data[7:0];
            state_d   = WR_LO;
         end
         WR_LO: begin
            addr_d    = word_addr(DST_BASE, idx_q, 1'b1);
            wr_en_d   = 1'b1;
            wr_data_d = out_hi_q;
            state_d   = WR_HI;
         end
         WR_HI: begin
            if (idx_q == LAST_IDX) begin
               state_d = FIN;
            end else begin
               idx_d   = idx_q + IW'(1);
               addr_d  = word_addr(SRC_BASE, idx_q + IW'(1), 1'b0);
               state_d = RD_LO;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         out_hi_q  <= '0;
         done_q    <= 1'b0;
         addr_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         ncor_q    <= '0;
         nunc_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         out_hi_q  <= out_hi_d;
         done_q    <= done_d;
         addr_q    <= addr_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         ncor_q    <= ncor_d;
         nunc_q    <= nunc_d;
      end
   end

   assign done            = done_q;
   assign mem_addr        = addr_q;
   assign mem_wr_en       = wr_en_q;
   assign mem_wr_data     = wr_data_q;
   assign n_corrected     = ncor_q;
   assign n_uncorrectable = nunc_q;

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Bench for hamming_dec_engine: behavioural memory, table vectors, random runs vs a search-based SECDED model.
module tb_hamming_dec_engine;

   localparam int SRC = 30;
   localparam int DST = 0;
   localparam int NW  = 15;
   localparam int CW  = 4;

   logic          CLK = 1'b0;
   logic          rst_n;
   logic          start;
   logic          done;
   logic [7:0]    mem_addr;
   logic [7:0]    mem_rd_data;
   logic          mem_wr_en;
   logic [7:0]    mem_wr_data;
   logic [CW-1:0] n_corrected;
   logic [CW-1:0] n_uncorrectable;

   always #5 CLK = ~CLK;

   hamming_dec_engine #(.SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW)) dut (
      .CLK(CLK), .rst_n(rst_n), .start(start), .done(done),
      .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
      .mem_wr_data(mem_wr_data), .n_corrected(n_corrected), .n_uncorrectable(n_uncorrectable)
   );

   // Memory: img is the image loaded per run; DUT writes land in wmem tagged with the run generation.
   logic [7:0] img  [256];
   logic [7:0] wmem [256];
   int         wgen [256];
   int         cur_gen  = 0;
   int         wr_count = 0;

   assign mem_rd_data = (wgen[mem_addr] == cur_gen) ? wmem[mem_addr] : img[mem_addr];

   always @(posedge CLK) begin
      if (mem_wr_en) begin
         wmem[mem_addr] <= mem_wr_data;
         wgen[mem_addr] <= cur_gen;
         wr_count       <= wr_count + 1;
      end
   end

   function automatic logic [7:0] rd(input int a);
      return (wgen[a & 255] == cur_gen) ? wmem[a & 255] : img[a & 255];
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: encode by placing data at non-power-of-two positions; decode by codeword search.
   function automatic logic [15:0] enc(input logic [10:0] m);
      logic [15:0] w;
      logic        x;
      int          j;
      w = '0;
      j = 0;
      for (int p = 1; p < 16; p++) begin
         if ((p & (p - 1)) != 0) begin
            w[p] = m[j];
            j++;
         end
      end
      for (int b = 0; b < 4; b++) begin
         x = 1'b0;
         for (int p = 1; p < 16; p++) begin
            if (p != (1 << b) && (p & (1 << b)) != 0) x = x ^ w[p];
         end
         w[1 << b] = x;
      end
      w[0] = ^w[15:1];
      return w;
   endfunction

   function automatic logic [10:0] ext(input logic [15:0] w);
      logic [10:0] m;
      int          j;
      m = '0;
      j = 0;
      for (int p = 1; p < 16; p++) begin
         if ((p & (p - 1)) != 0) begin
            m[j] = w[p];
            j++;
         end
      end
      return m;
   endfunction

   function automatic void model(input logic [15:0] w, output logic [7:0] lo, output logic [7:0] hi,
                                 output int cls);
      logic [10:0] d;
      logic [15:0] t;
      d = ext(w);
      if (enc(d) == w) begin
         cls = 0;
      end else begin
         cls = 2;
         for (int e = 0; e < 16; e++) begin
            t = w ^ (16'h1 << e);
            if (enc(ext(t)) == t) begin
               cls = 1;
               d   = ext(t);
            end
         end
      end
      lo = d[7:0];
      hi = {2'(cls), 3'b000, d[10:8]};
   endfunction

   logic [15:0] cur_w [NW];

   task automatic prep();
      cur_gen++;
      for (int k = 0; k < NW; k++) begin
         img[(SRC + 2 * k) & 255]     = cur_w[k][7:0];
         img[(SRC + 2 * k + 1) & 255] = cur_w[k][15:8];
      end
      for (int b = 0; b < 2 * NW; b++) img[(DST + b) & 255] = 8'hAA;
   endtask

   // Pulses start, optionally re-pulses start at edge pulse_at or drops reset at edge rst_at.
   task automatic do_run(input int pulse_at, input int rst_at, output int done_edge);
      int wc;
      @(negedge CLK);
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      chk("done_low_after_start", {31'd0, done}, 32'd0);
      done_edge = -1;
      for (int e = 1; e <= 200; e++) begin
         @(posedge CLK);
         #1;
         if (e == pulse_at) start = 1'b1;
         if (e == pulse_at + 1) start = 1'b0;
         if (e == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
            wc = wr_count;
            repeat (3) @(posedge CLK);
            @(negedge CLK);
            rst_n = 1'b1;
            repeat (10) @(posedge CLK);
            #1;
            chk("rst_no_writes", wr_count, wc);
            chk("rst_idle_done", {31'd0, done}, 32'd0);
            done_edge = -2;
            break;
         end
         if (done) begin
            done_edge = e;
            break;
         end
      end
   endtask

   // Compares the first nwords outputs against the model and the rest against the untouched sentinel.
   task automatic verify(input string tag, input int nwords, input logic check_cnt);
      logic [7:0] lo, hi;
      int         cls, ncor, nunc;
      logic       src_ok;
      ncor = 0;
      nunc = 0;
      for (int k = 0; k < NW; k++) begin
         model(cur_w[k], lo, hi, cls);
         if (k < nwords) begin
            if (cls == 1) ncor++;
            if (cls == 2) nunc++;
            chk({tag, "_lo"}, {24'd0, rd(DST + 2 * k)}, {24'd0, lo});
            chk({tag, "_hi"}, {24'd0, rd(DST + 2 * k + 1)}, {24'd0, hi});
         end else begin
            chk({tag, "_untouched"}, {16'd0, rd(DST + 2 * k + 1), rd(DST + 2 * k)}, 32'h0000AAAA);
         end
      end
      if (check_cnt) begin
         chk({tag, "_n_corrected"}, {28'd0, n_corrected}, ncor);
         chk({tag, "_n_uncorrectable"}, {28'd0, n_uncorrectable}, nunc);
      end
      src_ok = 1'b1;
      for (int k = 0; k < NW; k++) begin
         if ({rd(SRC + 2 * k + 1), rd(SRC + 2 * k)} !== cur_w[k]) src_ok = 1'b0;
      end
      chk({tag, "_src_intact"}, {31'd0, src_ok}, 32'd1);
   endtask

   typedef struct {
      logic [15:0] w;
      logic [7:0]  lo;
      logic [7:0]  hi;
   } vec_t;

   vec_t tbl [5];

   task automatic rand_fill(input int mode);
      int p1, p2, r;
      for (int k = 0; k < NW; k++) begin
         cur_w[k] = enc(11'($urandom));
         r = (mode == 0) ? $urandom_range(0, 99) : mode;
         if (r < 75 || r == 101) begin
            cur_w[k][$urandom_range(0, 15)] ^= 1'b1;
         end else if (r < 97 || r == 102) begin
            p1 = $urandom_range(0, 15);
            p2 = (p1 + $urandom_range(1, 15)) % 16;
            cur_w[k][p1] ^= 1'b1;
            cur_w[k][p2] ^= 1'b1;
         end
      end
   endtask

   int         de;
   logic [7:0] hb;

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{16'h0000, 8'h00, 8'h00};
      tbl[1] = '{16'hFFFF, 8'hFF, 8'h07};
      tbl[2] = '{16'hFFDF, 8'hFF, 8'h47};
      tbl[3] = '{16'hFFFE, 8'hFF, 8'h47};
      tbl[4] = '{16'hFFFC, 8'hFF, 8'h87};
      for (int a = 0; a < 256; a++) begin
         img[a] = 8'h00;
      end

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_wr_en", {31'd0, mem_wr_en}, 32'd0);
      chk("reset_addr", {24'd0, mem_addr}, 32'd0);
      chk("reset_wr_data", {24'd0, mem_wr_data}, 32'd0);
      chk("reset_counters", {24'd0, n_corrected, n_uncorrectable}, 32'd0);
      @(negedge CLK);
      rst_n = 1'b1;

      // Clean words only.
      for (int k = 0; k < NW; k++) cur_w[k] = (k % 2 == 0) ? 16'h0000 : 16'hFFFF;
      prep();
      do_run(-10, -10, de);
      $display("run clean: done at edge %0d, corr %0d, unc %0d", de, n_corrected, n_uncorrectable);
      chk("clean_done_edge", de, 76);
      verify("clean", NW, 1'b1);

      // Table vectors, three copies of each.
      for (int k = 0; k < NW; k++) cur_w[k] = tbl[k % 5].w;
      prep();
      do_run(-10, -10, de);
      $display("run table: done at edge %0d, corr %0d, unc %0d", de, n_corrected, n_uncorrectable);
      chk("table_done_edge", de, 76);
      for (int k = 0; k < NW; k++) begin
         chk("table_lo", {24'd0, rd(DST + 2 * k)}, {24'd0, tbl[k % 5].lo});
         chk("table_hi", {24'd0, rd(DST + 2 * k + 1)}, {24'd0, tbl[k % 5].hi});
      end
      chk("table_n_corrected", {28'd0, n_corrected}, 32'd6);
      chk("table_n_uncorrectable", {28'd0, n_uncorrectable}, 32'd3);

      // Sweep every flip position over two runs.
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < NW; k++) begin
            cur_w[k] = enc(11'($urandom));
            cur_w[k][(s == 0) ? k : 15] ^= 1'b1;
         end
         prep();
         do_run(-10, -10, de);
         $display("run sweep%0d: done at edge %0d, corr %0d", s, de, n_corrected);
         chk("sweep_done_edge", de, 76);
         for (int k = 0; k < NW; k++) begin
            hb = rd(DST + 2 * k + 1);
            chk("sweep_flag", {30'd0, hb[7:6]}, 32'd1);
         end
         verify("sweep", NW, 1'b1);
      end

      // All double errors.
      rand_fill(102);
      prep();
      do_run(-10, -10, de);
      $display("run double: done at edge %0d, unc %0d", de, n_uncorrectable);
      chk("double_done_edge", de, 76);
      for (int k = 0; k < NW; k++) begin
         hb = rd(DST + 2 * k + 1);
         chk("double_flag", {30'd0, hb[7:6]}, 32'd2);
      end
      verify("double", NW, 1'b1);

      // Random mixes.
      for (int r = 0; r < 4; r++) begin
         rand_fill(0);
         prep();
         do_run(-10, -10, de);
         $display("run mix%0d: done at edge %0d, corr %0d, unc %0d", r, de, n_corrected, n_uncorrectable);
         chk("mix_done_edge", de, 76);
         verify("mix", NW, 1'b1);
      end

      // Start pulsed mid-run is ignored.
      rand_fill(0);
      prep();
      do_run(20, -10, de);
      $display("run restart_pulse: done at edge %0d, corr %0d, unc %0d", de, n_corrected, n_uncorrectable);
      chk("pulse_done_edge", de, 76);
      verify("pulse", NW, 1'b1);

      // Reset mid-run: first six words written, rest untouched.
      rand_fill(0);
      prep();
      do_run(-10, 33, de);
      $display("run reset_abort: stopped at %0d, writes so far %0d", de, wr_count);
      chk("abort_marker", de, -2);
      verify("abort", 6, 1'b0);
      chk("abort_counters_cleared", {24'd0, n_corrected, n_uncorrectable}, 32'd0);

      // Normal run after the abort.
      rand_fill(0);
      prep();
      do_run(-10, -10, de);
      $display("run after_reset: done at edge %0d, corr %0d, unc %0d", de, n_corrected, n_uncorrectable);
      chk("after_done_edge", de, 76);
      verify("after", NW, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
